sd_writer: RTL and testbench

- Record-side counterpart of the SD sector reader: takes 8-bit unsigned audio samples at sample rate and packs them into 512-byte sectors.
- Writes the sectors sequentially to the SD card by driving the write side (wr/din/ready_for_next_byte) of the existing sd_controller, which runs at 25 MHz.
- Two 512-byte banks are used as a ping-pong buffer, so capture continues while a sector is being written.

---
 rtl/sd_writer.sv | 199 +++++++++++++++++++
 tb/tb_sd_writer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_writer.sv
// sd_writer: packs 8-bit audio samples into SD sectors via two ping-pong banks.
// Optional macro ZERO_SUB_EN: samples equal to 8'h00 are stored as 8'h01.
module sd_writer #(
    parameter int         SECTOR_BYTES = 512,
    parameter int         CNT_W        = 12,
    parameter logic [7:0] PAD_BYTE     = 8'h80
) (
    input  logic             clk_100mhz,
    input  logic             reset,
    input  logic [31:0]      start_addr,
    input  logic [CNT_W-1:0] num_sectors,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    input  logic             sd_ready,
    input  logic             sd_ready_for_next_byte,
    output logic             sd_wr,
    output logic [7:0]       sd_din,
    output logic [31:0]      sd_addr,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W-1:0] sectors_written
);
    localparam int IW = $clog2(SECTOR_BYTES);
    localparam logic [IW-1:0] LAST = IW'(SECTOR_BYTES - 1);
    localparam logic [31:0] STRIDE = 32'(SECTOR_BYTES);

    typedef enum logic [1:0] {C_IDLE, C_RECORD, C_FLUSH, C_DONE} ctrl_t;
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_DATA, D_WAIT} drain_t;

    ctrl_t  cstate;
    drain_t dstate;

    logic [7:0]       mem [2][SECTOR_BYTES];
    logic [1:0]       full;
    logic             fill_sel;
    logic             drain_sel;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    k;
    logic             rdy_q, rdy_s;
    logic             rfnb_q, rfnb_s, rfnb_d;
    logic             rfnb_rise;
    logic             release_bank;
    logic             fill_blocked;
    logic             entry;
    logic             wr_en;
    logic             fill_last;
    logic             drop;
    logic             pick;
    logic             reached;
    logic             reached_next;
    logic [7:0]       sample_st;
    logic [7:0]       wr_data;
    logic [CNT_W-1:0] cnt_next;

`ifdef ZERO_SUB_EN
    assign sample_st = (sample_in == 8'h00) ? 8'h01 : sample_in;
`else
    assign sample_st = sample_in;
`endif

    assign rfnb_rise    = rfnb_s & ~rfnb_d;
    assign release_bank = (dstate == D_WAIT) && rdy_s;
    // A bank released this cycle counts as empty for the filler.
    assign fill_blocked = full[fill_sel] &&
                          !(release_bank && drain_sel == fill_sel);
    assign entry        = start && (cstate == C_IDLE || cstate == C_DONE);
    assign wr_en        = (cstate == C_RECORD && sample_valid && !fill_blocked) ||
                          (cstate == C_FLUSH && idx != '0);
    assign wr_data      = (cstate == C_FLUSH) ? PAD_BYTE : sample_st;
    assign fill_last    = wr_en && idx == LAST;
    assign drop         = cstate == C_RECORD && sample_valid && fill_blocked;
    assign pick         = ~full[0];
    assign cnt_next     = (release_bank && sectors_written != '1) ?
                          sectors_written + 1'b1 : sectors_written;
    assign reached      = num_sectors != '0 && sectors_written == num_sectors;
    assign reached_next = num_sectors != '0 && cnt_next == num_sectors;

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            rdy_q  <= 1'b0;
            rdy_s  <= 1'b0;
            rfnb_q <= 1'b0;
            rfnb_s <= 1'b0;
            rfnb_d <= 1'b0;
        end else begin
            rdy_q  <= sd_ready;
            rdy_s  <= rdy_q;
            rfnb_q <= sd_ready_for_next_byte;
            rfnb_s <= rfnb_q;
            rfnb_d <= rfnb_s;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (wr_en) mem[fill_sel][idx] <= wr_data;
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            cstate   <= C_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            fill_sel <= 1'b0;
            idx      <= '0;
        end else begin
            if (wr_en) begin
                idx <= idx + 1'b1;
                if (fill_last) fill_sel <= ~fill_sel;
            end
            if (drop) overflow <= 1'b1;
            unique case (cstate)
                C_IDLE, C_DONE: begin
                    if (start) begin
                        cstate   <= C_RECORD;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                        fill_sel <= 1'b0;
                        idx      <= '0;
                    end
                end
                C_RECORD: begin
                    if (reached || (stop && reached_next)) begin
                        cstate <= C_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (stop) begin
                        cstate <= C_FLUSH;
                    end
                end
                C_FLUSH: begin
                    if (idx == '0 && dstate == D_IDLE && full == 2'b00) begin
                        cstate <= C_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            dstate          <= D_IDLE;
            drain_sel       <= 1'b0;
            k               <= '0;
            full            <= 2'b00;
            sd_wr           <= 1'b0;
            sd_din          <= 8'h00;
            sd_addr         <= 32'h0;
            sectors_written <= '0;
        end else begin
            if (release_bank) full[drain_sel] <= 1'b0;
            if (fill_last) full[fill_sel] <= 1'b1;
            unique case (dstate)
                D_IDLE: begin
                    if (full != 2'b00 && rdy_s) begin
                        drain_sel <= pick;
                        sd_din    <= mem[pick][0];
                        k         <= '0;
                        sd_wr     <= 1'b1;
                        dstate    <= D_REQ;
                    end
                end
                D_REQ: begin
                    if (!rdy_s) begin
                        sd_wr  <= 1'b0;
                        dstate <= D_DATA;
                    end
                end
                D_DATA: begin
                    if (rfnb_rise) begin
                        if (k == LAST) begin
                            dstate <= D_WAIT;
                        end else begin
                            k      <= k + 1'b1;
                            sd_din <= mem[drain_sel][k + 1'b1];
                        end
                    end
                end
                D_WAIT: begin
                    if (rdy_s) begin
                        sd_addr         <= sd_addr + STRIDE;
                        sectors_written <= cnt_next;
                        dstate          <= D_IDLE;
                    end
                end
            endcase
            if (entry) begin
                sd_addr         <= start_addr;
                sectors_written <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sd_writer.sv
// tb_sd_writer: directed sessions with random samples, checked against a
// queue model of the stored bytes and a 25 MHz sd_controller write model.
`timescale 1ns/1ps
module tb_sd_writer;
    localparam int CNT_W = 12;
    localparam int SB    = 512;

    logic             clk_100mhz = 1'b0;
    logic             clk_sd = 1'b0;
    logic             reset;
    logic [31:0]      start_addr;
    logic [CNT_W-1:0] num_sectors;
    logic             start;
    logic             stop;
    logic [7:0]       sample_in;
    logic             sample_valid;
    logic             sd_ready = 1'b0;
    logic             sd_ready_for_next_byte = 1'b0;
    logic             sd_wr;
    logic [7:0]       sd_din;
    logic [31:0]      sd_addr;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [CNT_W-1:0] sectors_written;

    sd_writer dut (
        .clk_100mhz             (clk_100mhz),
        .reset                  (reset),
        .start_addr             (start_addr),
        .num_sectors            (num_sectors),
        .start                  (start),
        .stop                   (stop),
        .sample_in              (sample_in),
        .sample_valid           (sample_valid),
        .sd_ready               (sd_ready),
        .sd_ready_for_next_byte (sd_ready_for_next_byte),
        .sd_wr                  (sd_wr),
        .sd_din                 (sd_din),
        .sd_addr                (sd_addr),
        .busy                   (busy),
        .done                   (done),
        .overflow               (overflow),
        .sectors_written        (sectors_written)
    );

    always #5 clk_100mhz = ~clk_100mhz;
    initial begin
        #2;
        forever #20 clk_sd = ~clk_sd;
    end

    // sd_controller write-side model: accepts wr, captures a byte, then
    // requests the next one with a one-cycle ready_for_next_byte pulse.
    typedef enum {M_READY, M_GAP, M_PULSE, M_BUSY} m_t;
    m_t          m_state = M_READY;
    bit          hold = 1'b0;
    int          m_gap = 0;
    int          m_byte = 0;
    logic [7:0]  cur [SB];
    logic [31:0] cur_addr;
    logic [7:0]  cap_q [$];
    logic [31:0] addr_q [$];

    always @(posedge clk_sd) begin
        if (reset) begin
            m_state = M_READY;
            sd_ready = 1'b0;
            sd_ready_for_next_byte = 1'b0;
        end else begin
            case (m_state)
                M_READY: begin
                    if (sd_ready && sd_wr) begin
                        sd_ready = 1'b0;
                        cur_addr = sd_addr;
                        m_byte = 0;
                        m_gap = 0;
                        m_state = M_GAP;
                    end else begin
                        sd_ready = !hold;
                    end
                end
                M_GAP: begin
                    m_gap++;
                    if (m_gap == 2) begin
                        cur[m_byte] = sd_din;
                        sd_ready_for_next_byte = 1'b1;
                        m_state = M_PULSE;
                    end
                end
                M_PULSE: begin
                    sd_ready_for_next_byte = 1'b0;
                    m_byte++;
                    m_gap = 0;
                    m_state = (m_byte == SB) ? M_BUSY : M_GAP;
                end
                M_BUSY: begin
                    m_gap++;
                    if (m_gap == 4) begin
                        for (int i = 0; i < SB; i++) cap_q.push_back(cur[i]);
                        addr_q.push_back(cur_addr);
                        sd_ready = !hold;
                        m_state = M_READY;
                    end
                end
            endcase
        end
    end

    int   wr_pulses = 0;
    logic wr_prev = 1'b0;
    always @(posedge clk_100mhz) begin
        if (sd_wr && !wr_prev) wr_pulses++;
        wr_prev = sd_wr;
    end

    int         total = 0;
    int         passed = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] stored(input logic [7:0] v);
`ifdef ZERO_SUB_EN
        return (v == 8'h00) ? 8'h01 : v;
`else
        return v;
`endif
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_100mhz);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic push(input logic [7:0] v, input int gap, input bit accept);
        sample_in = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        if (gap > 1) step(gap - 1);
        if (accept) exp_q.push_back(stored(v));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic check_sectors(input string tag, input int n,
                                 input logic [31:0] a0);
        int errs;
        check({tag, "_count"}, addr_q.size(), n);
        for (int s = 0; s < n; s++) begin
            if (addr_q.size() == 0) break;
            check({tag, "_addr"}, addr_q.pop_front(), a0 + 32'(s * SB));
            errs = 0;
            for (int i = 0; i < SB; i++) begin
                if (cap_q.size() == 0 || exp_q.size() == 0) errs++;
                else if (cap_q.pop_front() !== exp_q.pop_front()) errs++;
            end
            check({tag, "_data"}, errs, 0);
        end
        cap_q.delete();
        addr_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         w0;
        int         n;
        logic [7:0] z0;
        logic [7:0] b0, b1, b2;
`ifdef ZERO_SUB_EN
        z0 = 8'h01;
`else
        z0 = 8'h00;
`endif
        reset = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        sample_in = 8'h00;
        sample_valid = 1'b0;
        start_addr = 32'h0;
        num_sectors = '0;
        step(6);
        check("rst_wr", sd_wr, 1'b0);
        check("rst_din", sd_din, 8'h00);
        check("rst_addr", sd_addr, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_cnt", sectors_written, 0);
        reset = 1'b0;
        step(4);
        pulse_stop();
        step(2);
        check("idle_stop_ign", {busy, done}, 2'b00);

        // one sector, ramp 0..255
        start_addr = 32'h2C00;
        num_sectors = 1;
        w0 = wr_pulses;
        pulse_start();
        check("t1_busy", busy, 1'b1);
        for (int i = 0; i < SB; i++) push(8'(i % 256), $urandom_range(1, 3), 1'b1);
        wait_done("t1_done", 20000);
        check("t1_wr_pulses", wr_pulses - w0, 1);
        check("t1_addr_end", sd_addr, 32'h2E00);
        check("t1_cnt", sectors_written, 1);
        check("t1_busy_low", busy, 1'b0);
        check_sectors("t1", 1, 32'h2C00);

        // three back-to-back sectors; a start in RECORD must be ignored
        num_sectors = 3;
        w0 = wr_pulses;
        pulse_start();
        check("t2_cnt_clr", sectors_written, 0);
        check("t2_addr_load", sd_addr, 32'h2C00);
        for (int i = 0; i < 3 * SB; i++) begin
            if (i == 700) begin
                start_addr = 32'h9000;
                pulse_start();
                start_addr = 32'h2C00;
            end
            push(8'($urandom), $urandom_range(13, 17), 1'b1);
        end
        wait_done("t2_done", 20000);
        check("t2_wr_pulses", wr_pulses - w0, 3);
        check("t2_ovf", overflow, 1'b0);
        check("t2_cnt", sectors_written, 3);
        check("t2_addr_end", sd_addr, 32'h3200);
        check_sectors("t2", 3, 32'h2C00);

        // overflow: controller stalls, 1100 samples pushed
        hold = 1'b1;
        start_addr = 32'h10000;
        num_sectors = 0;
        pulse_start();
        for (int i = 0; i < 1100; i++) push(8'($urandom), 2, i < 2 * SB);
        check("t3_ovf", overflow, 1'b1);
        check("t3_cnt_stall", sectors_written, 0);
        hold = 1'b0;
        n = 0;
        while (sectors_written != 2 && n < 20000) begin
            step();
            n++;
        end
        check("t3_cnt", sectors_written, 2);
        pulse_stop();
        wait_done("t3_done", 20000);
        check("t3_ovf_sticky", overflow, 1'b1);
        check("t3_cnt_end", sectors_written, 2);
        check_sectors("t3", 2, 32'h10000);

        // stop after 100 samples: sector padded with 8'h80
        start_addr = 32'h40000;
        pulse_start();
        check("t4_ovf_clr", overflow, 1'b0);
        for (int i = 0; i < 100; i++) push(8'($urandom), $urandom_range(1, 3), 1'b1);
        pulse_stop();
        push(8'h55, 1, 1'b0);
        for (int i = 100; i < SB; i++) exp_q.push_back(8'h80);
        wait_done("t4_done", 20000);
        check("t4_cnt", sectors_written, 1);
        check("t4_ovf", overflow, 1'b0);
        check_sectors("t4", 1, 32'h40000);

        // reset while the controller is taking byte 200
        start_addr = 32'h50000;
        pulse_start();
        for (int i = 0; i < SB; i++) push(8'($urandom), 1, 1'b0);
        n = 0;
        while (!(m_state == M_GAP && m_byte == 200) && n < 20000) begin
            step();
            n++;
        end
        check("t5_reach_byte200", n < 20000, 1'b1);
        reset = 1'b1;
        step(6);
        check("t5_wr", sd_wr, 1'b0);
        check("t5_din", sd_din, 8'h00);
        check("t5_addr", sd_addr, 32'h0);
        check("t5_flags", {busy, done, overflow}, 3'b000);
        check("t5_cnt", sectors_written, 0);
        reset = 1'b0;
        cap_q.delete();
        addr_q.delete();
        exp_q.delete();
        step(8);
        start_addr = 32'h2C00;
        num_sectors = 1;
        pulse_start();
        for (int i = 0; i < SB; i++) push(8'($urandom), 1, 1'b1);
        wait_done("t5_done", 20000);
        check("t5_cnt_end", sectors_written, 1);
        check_sectors("t5", 1, 32'h2C00);

        // zero substitution
        start_addr = 32'h60000;
        num_sectors = 0;
        pulse_start();
        push(8'h00, 3, 1'b1);
        push(8'h7F, 3, 1'b1);
        push(8'h00, 3, 1'b1);
        pulse_stop();
        for (int i = 3; i < SB; i++) exp_q.push_back(8'h80);
        wait_done("t6_done", 20000);
        b0 = 8'hxx;
        b1 = 8'hxx;
        b2 = 8'hxx;
        if (cap_q.size() > 2) begin
            b0 = cap_q[0];
            b1 = cap_q[1];
            b2 = cap_q[2];
        end
        check("t6_b0", b0, z0);
        check("t6_b1", b1, 8'h7F);
        check("t6_b2", b2, z0);
        check_sectors("t6", 1, 32'h60000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
